// File: rtl/turbo_rsc_frame_encoder_pkg.sv
// Shared definitions for the LTE constituent RSC frame encoder (g0=13, g1=15 octal).
// Tap vectors are ordered {a, D, D^2, D^3}; trellis state is packed as {s2, s1, s0}.
package turbo_rsc_frame_encoder_pkg;

  localparam int WORD_W = 64;
  localparam int INFO_W = 32;

  localparam logic [3:0] G0 = 4'b1011;
  localparam logic [3:0] G1 = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    FLUSH = 2'd3
  } enc_state_e;

  // Feedback contribution of the delay line (everything in g0 except the input tap).
  function automatic logic fb_tap(input logic [2:0] s);
    return ^(G0[2:0] & {s[0], s[1], s[2]});
  endfunction

  // Parity contribution of the delay line (everything in g1 except the a tap).
  function automatic logic par_tap(input logic [2:0] s);
    return ^(G1[2:0] & {s[0], s[1], s[2]});
  endfunction

endpackage

// File: rtl/turbo_rsc_frame_encoder_rsc_step32.sv
// Combinational unroll of 32 RSC trellis steps; bit 0 is encoded first.
// Output word interleaves systematic (even bits) and parity (odd bits).
module turbo_rsc_frame_encoder_rsc_step32
  import turbo_rsc_frame_encoder_pkg::*;
(
  input  logic [2:0]        state_in,
  input  logic [INFO_W-1:0] bits,
  output logic [WORD_W-1:0] word,
  output logic [2:0]        state_out
);

  always_comb begin
    logic [2:0] s;
    logic       a;
    s    = state_in;
    a    = 1'b0;
    word = '0;
    for (int i = 0; i < INFO_W; i++) begin
      a             = bits[i] ^ fb_tap(s);
      word[2*i]     = bits[i];
      word[2*i+1]   = (G1[3] & a) ^ par_tap(s);
      s             = {s[1], s[0], a};
    end
    state_out = s;
  end

endmodule

// File: rtl/turbo_rsc_frame_encoder.sv
// Frame-level RSC encoder: one 64-bit sys/par word per 32-bit input word, then a
// trellis termination word, written through a single-entry slot into a wren/din/full FIFO.
//
// state | meaning
// IDLE  | waiting for start; slot empty
// DATA  | accepting WORDS input words
// TAIL  | waiting for a free slot to load the termination word
// FLUSH | termination word in slot; frame_done on its write
module turbo_rsc_frame_encoder
  import turbo_rsc_frame_encoder_pkg::*;
#(
  parameter int FRAME_BITS = 6144
) (
  input  logic              clk_dp,
  input  logic              clk_dp_rst_n,
  input  logic              start,
  input  logic [31:0]       info_din,
  input  logic              info_valid,
  output logic              info_ready,
  output logic              enc_fifo_wren,
  output logic [WORD_W-1:0] enc_fifo_din,
  input  logic              enc_fifo_full,
  output logic              busy,
  output logic              frame_done
);

  localparam int              WORDS     = FRAME_BITS / 32;
  localparam int              CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  enc_state_e        state_q, state_d;
  logic [2:0]        trellis_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] slot_q;
  logic              slot_vld_q;

  logic              slot_free;
  logic              accept;
  logic              clear_frame;
  logic              load_tail;
  logic [WORD_W-1:0] data_word;
  logic [2:0]        data_next;
  logic [WORD_W-1:0] tail_word;
  logic [2:0]        tail_next;

  assign enc_fifo_wren = slot_vld_q & ~enc_fifo_full;
  assign enc_fifo_din  = slot_q;
  // A slot being drained this cycle can be refilled in the same cycle.
  assign slot_free     = ~slot_vld_q | enc_fifo_wren;
  assign info_ready    = (state_q == DATA) & slot_free;
  assign accept        = info_valid & info_ready;
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == FLUSH) & enc_fifo_wren;

  turbo_rsc_frame_encoder_rsc_step32 u_step (
    .state_in  (trellis_q),
    .bits      (info_din),
    .word      (data_word),
    .state_out (data_next)
  );

  // Termination: drive u so the feedback node is zero, three times.
  always_comb begin
    logic [2:0] s;
    logic       u;
    s         = trellis_q;
    u         = 1'b0;
    tail_word = '0;
    for (int k = 0; k < 3; k++) begin
      u              = fb_tap(s);
      tail_word[2*k]   = u;
      tail_word[2*k+1] = par_tap(s);
      s              = {s[1], s[0], 1'b0};
    end
    tail_next = s;
  end

  always_ff @(posedge clk_dp or negedge clk_dp_rst_n) begin
    if (!clk_dp_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_frame = 1'b0;
    load_tail   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = DATA;
          clear_frame = 1'b1;
        end
      end
      DATA: begin
        if (accept && (cnt_q == LAST_WORD)) begin
          state_d = TAIL;
        end
      end
      TAIL: begin
        if (slot_free) begin
          state_d   = FLUSH;
          load_tail = 1'b1;
        end
      end
      FLUSH: begin
        if (enc_fifo_wren) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_dp or negedge clk_dp_rst_n) begin
    if (!clk_dp_rst_n) begin
      trellis_q <= 3'b000;
      cnt_q     <= '0;
    end else if (clear_frame) begin
      trellis_q <= 3'b000;
      cnt_q     <= '0;
    end else if (accept) begin
      trellis_q <= data_next;
      if (cnt_q != LAST_WORD) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (load_tail) begin
      trellis_q <= tail_next;
    end
  end

  always_ff @(posedge clk_dp or negedge clk_dp_rst_n) begin
    if (!clk_dp_rst_n) begin
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
    end else if (accept) begin
      slot_q     <= data_word;
      slot_vld_q <= 1'b1;
    end else if (load_tail) begin
      slot_q     <= tail_word;
      slot_vld_q <= 1'b1;
    end else if (enc_fifo_wren) begin
      slot_vld_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_turbo_rsc_frame_encoder.sv
// Directed and randomised checks of the RSC frame encoder against a bit-level reference
// model, with FRAME_BITS=64 (two input words per frame).
module tb_turbo_rsc_frame_encoder;

  localparam int FRAME_BITS = 64;
  localparam int WORDS      = FRAME_BITS / 32;

  logic        clk_dp       = 1'b0;
  logic        clk_dp_rst_n = 1'b0;
  logic        start        = 1'b0;
  logic [31:0] info_din     = '0;
  logic        info_valid   = 1'b0;
  logic        dir_full     = 1'b0;
  logic        rnd_full     = 1'b0;
  logic        rand_full_en = 1'b0;
  logic        enc_fifo_full;
  logic        info_ready;
  logic        enc_fifo_wren;
  logic [63:0] enc_fifo_din;
  logic        busy;
  logic        frame_done;

  int          n_cmp = 0;
  int          n_err = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] fw[WORDS];
  logic [2:0]  m_s;
  int          wr_total    = 0;
  int          done_total  = 0;
  int          done_wr_idx = -1;
  int          stray_done  = 0;

  assign enc_fifo_full = dir_full | (rand_full_en & rnd_full);

  always #5 clk_dp = ~clk_dp;

  turbo_rsc_frame_encoder #(.FRAME_BITS(FRAME_BITS)) dut (
    .clk_dp        (clk_dp),
    .clk_dp_rst_n  (clk_dp_rst_n),
    .start         (start),
    .info_din      (info_din),
    .info_valid    (info_valid),
    .info_ready    (info_ready),
    .enc_fifo_wren (enc_fifo_wren),
    .enc_fifo_din  (enc_fifo_din),
    .enc_fifo_full (enc_fifo_full),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Write monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk_dp) begin
    if (enc_fifo_wren) begin
      got_q.push_back(enc_fifo_din);
      wr_total++;
    end
    if (frame_done) begin
      done_total++;
      done_wr_idx = got_q.size();
      if (!enc_fifo_wren) stray_done++;
    end
  end

  initial begin
    forever begin
      @(posedge clk_dp);
      #1;
      rnd_full = ($urandom_range(0, 3) == 0);
    end
  end

  // Reference model written directly from a = u^s1^s2, p = a^s0^s2; m_s = {s2,s1,s0}.
  task automatic model_word(input logic [31:0] w, output logic [63:0] o);
    logic a;
    o = '0;
    for (int i = 0; i < 32; i++) begin
      a          = w[i] ^ m_s[1] ^ m_s[2];
      o[2*i]     = w[i];
      o[2*i+1]   = a ^ m_s[0] ^ m_s[2];
      m_s        = {m_s[1], m_s[0], a};
    end
  endtask

  task automatic model_tail(output logic [63:0] o);
    logic u;
    o = '0;
    for (int k = 0; k < 3; k++) begin
      u          = m_s[1] ^ m_s[2];
      o[2*k]     = u;
      o[2*k+1]   = m_s[0] ^ m_s[2];
      m_s        = {m_s[1], m_s[0], 1'b0};
    end
  endtask

  task automatic build_expected();
    logic [63:0] o;
    m_s = 3'b000;
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) begin
      model_word(fw[i], o);
      exp_q.push_back(o);
    end
    model_tail(o);
    exp_q.push_back(o);
  endtask

  task automatic start_frame();
    @(posedge clk_dp); #1;
    start = 1'b1;
    @(posedge clk_dp); #1;
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input int vstall);
    int g;
    g = 0;
    for (int s = 0; s < vstall; s++) begin
      info_valid = 1'b0;
      @(posedge clk_dp); #1;
    end
    info_din   = w;
    info_valid = 1'b1;
    forever begin
      @(negedge clk_dp);
      if (info_ready) break;
      g++;
      if (g >= 300) break;
    end
    if (g >= 300) check("push_timeout", 64'(g), 64'd0);
    @(posedge clk_dp); #1;
    info_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int g;
    g = 0;
    while (done_total == d0 && g < 400) begin
      @(posedge clk_dp); #1;
      g++;
    end
    check({tag, "_done_count"}, 64'(done_total - d0), 64'd1);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_nwr"}, 64'(got_q.size()), 64'(WORDS + 1));
    for (int i = 0; i < WORDS + 1 && i < got_q.size(); i++)
      check({tag, "_word"}, got_q[i], exp_q[i]);
    check({tag, "_done_at"}, 64'(done_wr_idx), 64'(WORDS + 1));
  endtask

  task automatic run_frame(input string tag, input int vmax);
    int d0;
    build_expected();
    got_q.delete();
    d0 = done_total;
    start_frame();
    for (int i = 0; i < WORDS; i++) push_word(fw[i], int'($urandom_range(0, vmax)));
    wait_done(tag, d0);
    @(posedge clk_dp); #1;
    compare_frame(tag);
  endtask

  initial begin
    #40 watchdog_arm();
  end

  task automatic watchdog_arm();
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  endtask

  initial begin
    int d0;
    int bad_wren;
    int bad_din;
    int bad_ready;

    // Reset state
    #12;
    check("rst_busy",       64'(busy),          64'd0);
    check("rst_wren",       64'(enc_fifo_wren), 64'd0);
    check("rst_ready",      64'(info_ready),    64'd0);
    check("rst_frame_done", 64'(frame_done),    64'd0);
    check("rst_din",        enc_fifo_din,       64'd0);
    @(posedge clk_dp); #1;
    clk_dp_rst_n = 1'b1;
    @(posedge clk_dp); #1;

    // All-zero frame: three zero writes, frame_done on the third
    fw[0] = 32'h0; fw[1] = 32'h0;
    run_frame("zero", 0);
    if (got_q.size() >= 3) check("zero_tail_const", got_q[2], 64'h0);

    // Impulse, with a start pulse mid-frame that must be ignored
    fw[0] = 32'h0000_0001; fw[1] = 32'h0;
    build_expected();
    got_q.delete();
    d0 = done_total;
    start_frame();
    push_word(fw[0], 0);
    start = 1'b1;
    @(posedge clk_dp); #1;
    start = 1'b0;
    push_word(fw[1], 0);
    wait_done("impulse", d0);
    @(posedge clk_dp); #1;
    compare_frame("impulse");
    if (got_q.size() >= 1) check("impulse_low_byte", 64'(got_q[0][7:0]), 64'hAB);

    // Last bit set: hand-computed data and tail words, trellis back to zero
    fw[0] = 32'h0; fw[1] = 32'h8000_0000;
    run_frame("msb", 0);
    if (got_q.size() >= 3) begin
      check("msb_data_const", got_q[1], 64'hC000_0000_0000_0000);
      check("msb_tail_const", got_q[2], 64'h0000_0000_0000_0036);
    end
    check("msb_trellis_zero", 64'(dut.trellis_q), 64'd0);

    // Full held for 10 cycles with the next word presented
    fw[0] = 32'hDEAD_BEEF; fw[1] = 32'h1234_5678;
    build_expected();
    got_q.delete();
    d0 = done_total;
    start_frame();
    push_word(fw[0], 0);
    dir_full   = 1'b1;
    info_din   = fw[1];
    info_valid = 1'b1;
    bad_wren = 0; bad_din = 0; bad_ready = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_dp);
      if (enc_fifo_wren) bad_wren++;
      if (enc_fifo_din !== exp_q[0]) bad_din++;
      if (info_ready) bad_ready++;
    end
    check("hold_wren_cycles",  64'(bad_wren),  64'd0);
    check("hold_din_unstable", 64'(bad_din),   64'd0);
    check("hold_ready_cycles", 64'(bad_ready), 64'd0);
    @(posedge clk_dp); #1;
    dir_full = 1'b0;
    push_word(fw[1], 0);
    wait_done("hold", d0);
    @(posedge clk_dp); #1;
    compare_frame("hold");

    // Reset mid-frame with the first word stuck in the slot
    fw[0] = 32'hA5A5_0F0F; fw[1] = 32'h0000_FFFF;
    got_q.delete();
    d0 = done_total;
    start_frame();
    push_word(fw[0], 0);
    dir_full = 1'b1;
    @(posedge clk_dp); #1;
    @(posedge clk_dp); #1;
    clk_dp_rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy),          64'd0);
    check("midrst_wren", 64'(enc_fifo_wren), 64'd0);
    @(posedge clk_dp); #1;
    clk_dp_rst_n = 1'b1;
    dir_full     = 1'b0;
    got_q.delete();
    repeat (5) begin
      @(posedge clk_dp); #1;
    end
    check("midrst_stale_writes", 64'(got_q.size()),   64'd0);
    check("midrst_no_done",      64'(done_total - d0), 64'd0);
    run_frame("after_rst", 0);

    // Random frames with valid and full stalls
    rand_full_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      fw[0] = $urandom;
      fw[1] = $urandom;
      run_frame("rand", 2);
    end
    rand_full_en = 1'b0;

    check("stray_frame_done", 64'(stray_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
